// File: rtl/multicycle_adder_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_adder_pkg
//   Shared definitions for the chunked sequential adder.
//   - state_e   : control FSM states (IDLE -> BUSY -> DONE -> IDLE)
//   - idx_width : width of the chunk index counter (minimum 1 bit)
// -----------------------------------------------------------------------------
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/multicycle_adder_chunk.sv
// -----------------------------------------------------------------------------
// chunk_adder
//   Purely combinational CHUNK-bit adder with carry in/out. The top instantiates
//   exactly one of these and multiplexes the operand slices into it, so the
//   critical carry path is only CHUNK bits long.
// Ports
//   a, b : CHUNK-bit operand slices
//   ci   : carry in
//   s    : CHUNK-bit sum slice
//   co   : carry out of the slice MSB
// -----------------------------------------------------------------------------
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
//   WIDTH-bit add/subtract that processes CHUNK bits per clock with a
//   registered inter-chunk carry. Operands are captured at an accepted start;
//   sum/cf/of update only on the cycle that done pulses and are held until the
//   next operation completes.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request an op; sampled only in IDLE or DONE
//   sub    : 0 = a+b+cin, 1 = a-b (cin ignored)
//   a, b   : operands
//   cin    : carry-in for add
//   sum    : registered result
//   cf     : carry out of MSB (sub: 1 = no borrow)
//   of     : signed overflow
//   busy   : high while chunks are being processed
//   done   : one-cycle pulse when sum/cf/of update
// -----------------------------------------------------------------------------
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cf,
  output logic             of,
  output logic             busy,
  output logic             done
);

  // Guard the divide so a bad CHUNK reports the intended error instead of
  // failing elaboration on a division by zero.
  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
  localparam int IDXW       = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK_SAFE) != 0) begin : g_bad_params
      $error("multicycle_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
             WIDTH, CHUNK);
    end
  endgenerate

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;      // effective B (already inverted for sub)
  logic [WIDTH-1:0]  acc_q, acc_d;  // partial result, never visible on outputs
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cf_q, cf_d;
  logic              of_q, of_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Operand slices laid out as arrays so the per-cycle mux is a plain index.
  logic [CHUNK_SAFE-1:0] a_slices [NCHUNK];
  logic [CHUNK_SAFE-1:0] b_slices [NCHUNK];

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_slices
      assign a_slices[gi] = a_q[gi*CHUNK_SAFE +: CHUNK_SAFE];
      assign b_slices[gi] = b_q[gi*CHUNK_SAFE +: CHUNK_SAFE];
    end
  endgenerate

  logic [CHUNK_SAFE-1:0] a_chunk, b_chunk, s_chunk;
  logic                  co_chunk;
  logic [WIDTH-1:0]      acc_upd;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_chunk = a_slices[i];
        b_chunk = b_slices[i];
      end
    end
  end

  chunk_adder #(
    .CHUNK (CHUNK_SAFE)
  ) u_chunk (
    .a  (a_chunk),
    .b  (b_chunk),
    .ci (carry_q),
    .s  (s_chunk),
    .co (co_chunk)
  );

  // Accumulator with the current slice replaced; on the last chunk this is
  // the complete result and goes straight to the output register.
  always_comb begin
    acc_upd = acc_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        acc_upd[i*CHUNK_SAFE +: CHUNK_SAFE] = s_chunk;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cf_d    = cf_q;
    of_d    = of_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        acc_d   = acc_upd;
        carry_d = co_chunk;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_upd;
          cf_d    = co_chunk;
          of_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_upd[WIDTH-1] != a_q[WIDTH-1]);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cf_q    <= cf_d;
      of_q    <= of_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cf   = cf_q;
  assign of   = of_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// -----------------------------------------------------------------------------
// tb_multicycle_adder
//   Directed checks on an 8/2 instance, a single-cycle 16/16 instance and a
//   randomised run on a 32/4 instance against an arithmetic reference.
// -----------------------------------------------------------------------------
module tb_multicycle_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- 8-bit, CHUNK=2 ----------------
  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8, sum8;
  logic        cf8, of8, busy8, done8;

  multicycle_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .sum(sum8), .cf(cf8), .of(of8), .busy(busy8), .done(done8)
  );

  // ---------------- 16-bit, CHUNK=16 ----------------
  logic        start16, sub16, cin16;
  logic [15:0] a16, b16, sum16;
  logic        cf16, of16, busy16, done16;

  multicycle_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .cin(cin16), .sum(sum16), .cf(cf16), .of(of16), .busy(busy16), .done(done16)
  );

  // ---------------- 32-bit, CHUNK=4 ----------------
  logic        start32, sub32, cin32;
  logic [31:0] a32, b32, sum32;
  logic        cf32, of32, busy32, done32;

  multicycle_adder #(.WIDTH(32), .CHUNK(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .cin(cin32), .sum(sum32), .cf(cf32), .of(of32), .busy(busy32), .done(done32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (sampling 1ns after each rising edge) until done8 rises; returns the
  // number of edges waited, capped at a bound.
  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (!done8 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                     input logic c_v, input logic s_v,
                     input logic [7:0] e_sum, input logic e_cf, input logic e_of);
    int cyc;
    @(negedge clk);
    a8 = a_v; b8 = b_v; cin8 = c_v; sub8 = s_v; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check({tag, "_busy"}, 64'(busy8), 64'd1);
    wait_done8(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'd4);
    check({tag, "_sum"}, 64'(sum8), 64'(e_sum));
    check({tag, "_cf"},  64'(cf8),  64'(e_cf));
    check({tag, "_of"},  64'(of8),  64'(e_of));
    check({tag, "_busy_end"}, 64'(busy8), 64'd0);
    $display("op %s a=%h b=%h cin=%b sub=%b -> sum=%h cf=%b of=%b lat=%0d",
             tag, a_v, b_v, c_v, s_v, sum8, cf8, of8, cyc);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(done8), 64'd0);
  endtask

  initial begin
    int cyc;
    int dcount;
    logic [31:0] ra, rb, bb;
    logic        rc, rs, ec, e_of;
    logic [32:0] full;

    rst_n = 1'b0;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
    start16 = 0; sub16 = 0; cin16 = 0; a16 = '0; b16 = '0;
    start32 = 0; sub32 = 0; cin32 = 0; a32 = '0; b32 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sum",  64'(sum8),  64'd0);
    check("rst_cf",   64'(cf8),   64'd0);
    check("rst_of",   64'(of8),   64'd0);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Add / subtract vectors
    op8("add_24_a7", 8'h24, 8'hA7, 1'b0, 1'b0, 8'hCB, 1'b0, 1'b0);
    op8("add_80_a7", 8'h80, 8'hA7, 1'b0, 1'b0, 8'h27, 1'b1, 1'b1);
    op8("add_ff_ff", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    op8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Result held while idle
    repeat (3) @(posedge clk);
    #1;
    check("hold_sum", 64'(sum8), 64'h7F);
    check("hold_cf",  64'(cf8),  64'd1);

    // Start during BUSY ignored; operands changing during BUSY have no effect
    @(negedge clk);
    a8 = 8'h24; b8 = 8'hA7; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; sub8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'hFF; cin8 = 1'b1;
    cyc = 3;
    while (!done8 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ign_lat", 64'(cyc), 64'd4);
    check("ign_sum", 64'(sum8), 64'hCB);
    check("ign_cf",  64'(cf8),  64'd0);
    $display("op ignore_start a=24 b=a7 -> sum=%h cf=%b of=%b", sum8, cf8, of8);

    // Back-to-back: start high while in DONE
    a8 = 8'h10; b8 = 8'h05; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("b2b_done_pulse", 64'(done8), 64'd0);
    check("b2b_busy", 64'(busy8), 64'd1);
    check("b2b_sum_held", 64'(sum8), 64'hCB);
    wait_done8(cyc);
    check("b2b_lat", 64'(cyc), 64'd4);
    check("b2b_sum", 64'(sum8), 64'h16);
    $display("op back_to_back a=10 b=05 cin=1 -> sum=%h cf=%b of=%b lat=%0d", sum8, cf8, of8, cyc);

    // Reset in the middle of an operation
    @(negedge clk);
    a8 = 8'h80; b8 = 8'hA7; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy8), 64'd0);
    check("mrst_done", 64'(done8), 64'd0);
    check("mrst_sum",  64'(sum8),  64'd0);
    check("mrst_cf",   64'(cf8),   64'd0);
    check("mrst_of",   64'(of8),   64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done8 || busy8) dcount++;
    end
    check("mrst_no_done", 64'(dcount), 64'd0);
    $display("op reset_abort -> sum=%h busy=%b done=%b", sum8, busy8, done8);

    // Single-chunk configuration
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w16_lat", 64'(cyc), 64'd1);
    check("w16_sum", 64'(sum16), 64'h0000);
    check("w16_cf",  64'(cf16),  64'd1);
    check("w16_of",  64'(of16),  64'd0);
    $display("op w16 a=ffff b=0001 -> sum=%h cf=%b of=%b lat=%0d", sum16, cf16, of16, cyc);

    // Randomised 32-bit run against an arithmetic reference
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if (n == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h0000_0001; rs = 1'b0; rc = 1'b0; end
      if (n == 1) begin ra = 32'h7FFF_FFFF; rb = 32'hFFFF_FFFF; rs = 1'b1; end
      bb   = rs ? ~rb : rb;
      ec   = rs ? 1'b1 : rc;
      full = {1'b0, ra} + {1'b0, bb} + {32'd0, ec};
      e_of = (ra[31] == bb[31]) && (full[31] != ra[31]);

      @(negedge clk);
      a32 = ra; b32 = rb; cin32 = rc; sub32 = rs; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      cyc = 0;
      while (!done32 && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("w32_lat", 64'(cyc), 64'd8);
      check("w32_sum", 64'(sum32), 64'(full[31:0]));
      check("w32_cf",  64'(cf32),  64'(full[32]));
      check("w32_of",  64'(of32),  64'(e_of));
      $display("op w32 #%0d a=%h b=%h cin=%b sub=%b -> sum=%h cf=%b of=%b",
               n, ra, rb, rc, rs, sum32, cf32, of32);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
